// File: rtl/axil_pkg.sv
// axil_pkg: response codes and FSM state types shared by the AXI-Lite SRAM responder
package axil_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;
endpackage

// File: rtl/sram_1r1w.sv
// sram_1r1w: DEPTH x 32 word array, combinational read port, byte-enabled write port
module sram_1r1w #(
    parameter int DEPTH = 65536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic [AW-1:0] waddr,
    input  logic [3:0]    wbe,
    input  logic [31:0]   wdata
);
    logic [31:0] mem [DEPTH];
    assign rdata = mem[raddr];
    // Byte-lane write; a read registered on this same edge still sees the old word
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/axil_sram_responder.sv
// axil_sram_responder: AXI4-Lite responder over a word SRAM with programmable reply latency
module axil_sram_responder
    import axil_pkg::*;
#(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 65536,
    parameter logic [ADDR_W-1:0] BASE    = 32'h8000_0000,
    parameter int                LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ADDR_W-1:0] araddr,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [7:0]        wstrb,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp
);
    localparam int                IW   = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * DEPTH);

    rd_state_t         rstate;
    wr_state_t         wstate;
    logic [3:0]        rcnt, wcnt;
    logic [ADDR_W-1:0] ar_addr, aw_addr, r_off, w_off;
    logic [DATA_W-1:0] w_data, mem_rdata;
    logic [3:0]        w_strb, mem_wbe;
    logic              aw_got, w_got, aw_now, w_now, r_ok, w_ok, commit;

    assign r_off   = ar_addr - BASE;
    assign w_off   = aw_addr - BASE;
    assign r_ok    = (ar_addr >= BASE) && (r_off < SPAN);
    assign w_ok    = (aw_addr >= BASE) && (w_off < SPAN);
    assign commit  = !rst && wstate == W_WAIT && wcnt == 4'd0;
    assign mem_wbe = (commit && w_ok) ? w_strb : 4'b0;
    assign aw_now  = aw_got | (awvalid & awready);
    assign w_now   = w_got | (wvalid & wready);

    sram_1r1w #(.DEPTH(DEPTH), .AW(IW)) u_sram (
        .clk   (clk),
        .raddr (r_off[IW+1:2]),
        .rdata (mem_rdata),
        .waddr (w_off[IW+1:2]),
        .wbe   (mem_wbe),
        .wdata (w_data)
    );

    // Read path: accept AR, count down the latency, present R until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rcnt    <= 4'd0;
            ar_addr <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        ar_addr <= araddr;
                        arready <= 1'b0;
                        rcnt    <= 4'(LATENCY);
                        rstate  <= R_WAIT;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rcnt == 4'd0) begin
                        rdata  <= r_ok ? mem_rdata : '0;
                        rresp  <= r_ok ? RESP_OKAY : RESP_DECERR;
                        rvalid <= 1'b1;
                        rstate <= R_RESP;
                    end else begin
                        rcnt <= rcnt - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // Write path: collect AW and W in any order, wait the latency, commit, present B
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            wcnt    <= 4'd0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= 4'b0;
        end else begin
            if (awvalid && awready) aw_addr <= awaddr;
            if (wvalid && wready) begin
                w_data <= wdata;
                w_strb <= wstrb[3:0];
            end
            case (wstate)
                W_IDLE: begin
                    if (aw_now && w_now) begin
                        aw_got  <= 1'b0;
                        w_got   <= 1'b0;
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        wcnt    <= 4'(LATENCY);
                        wstate  <= W_WAIT;
                    end else begin
                        aw_got  <= aw_now;
                        w_got   <= w_now;
                        awready <= !aw_now;
                        wready  <= !w_now;
                    end
                end
                W_WAIT: begin
                    if (wcnt == 4'd0) begin
                        bresp  <= w_ok ? RESP_OKAY : RESP_DECERR;
                        bvalid <= 1'b1;
                        wstate <= W_RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_sram_responder.sv
// tb_axil_sram_responder: directed checks of latency, strobes, ordering, decode errors, backpressure and reset
module tb_axil_sram_responder;
    import axil_pkg::*;
    localparam int LAT = 2;

    logic        clk = 1'b0, rst = 1'b1;
    logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
    logic [31:0] araddr = '0, rdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0;
    logic [7:0]  wstrb = '0;
    int vectors = 0, miscompares = 0, cyc = 0;

    axil_sram_responder #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1);
    end

    task automatic ar_send(input logic [31:0] a, output int t);
        int n;
        n = 0;
        araddr  = a;
        arvalid = 1'b1;
        while (arready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n == 40) begin
            vectors++; miscompares++;
            $display("FAIL ar_timeout: arready stayed low for %0d cycles, required within 40", n);
        end
        t = cyc + 1;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic r_get(output logic [31:0] d, output logic [1:0] r, output int t);
        int n;
        n = 0;
        while (rvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n == 40) begin
            vectors++; miscompares++;
            $display("FAIL r_timeout: rvalid stayed low for %0d cycles, required within 40", n);
        end
        t = cyc;
        d = rdata;
        r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wr_send(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                           input int w_lead, output int t_late);
        int  n, k;
        logic aw_done, w_done;
        n = 0; k = 0; t_late = 0;
        aw_done = 1'b0; w_done = 1'b0;
        awaddr = a; wdata = d; wstrb = s;
        wvalid  = 1'b1;
        awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && n < 60) begin
            if (awvalid && awready) begin aw_done = 1'b1; t_late = cyc + 1; end
            if (wvalid && wready) begin w_done = 1'b1; t_late = cyc + 1; end
            @(negedge clk);
            n++; k++;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            if (!aw_done && k >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (n == 60) begin
            vectors++; miscompares++;
            $display("FAIL aw_w_timeout: handshakes aw=%0b w=%0b after %0d cycles, required both", aw_done, w_done, n);
        end
    endtask

    task automatic b_get(output logic [1:0] r, output int t);
        int n;
        n = 0;
        while (bvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n == 40) begin
            vectors++; miscompares++;
            $display("FAIL b_timeout: bvalid stayed low for %0d cycles, required within 40", n);
        end
        t = cyc;
        r = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s, output logic [1:0] r);
        int tl, tb;
        wr_send(a, d, s, 0, tl);
        b_get(r, tb);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int t, tr;
        ar_send(a, t);
        r_get(d, r, tr);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp} !== 41'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h, required 0", {arready, awready, wready, rvalid, bvalid, rdata, rresp, bresp});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({arready, awready, wready} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_ready: ar/aw/w ready got %b, required 111", {arready, awready, wready});
        end
    endtask

    task automatic test_read_latency;
        logic [31:0] d;
        logic [1:0]  r;
        int t, tr;
        wr(32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, r);
        vectors++;
        if (r !== RESP_OKAY) begin miscompares++; $display("FAIL preload_bresp: got %b, required 00", r); end
        ar_send(32'h8000_0010, t);
        r_get(d, r, tr);
        vectors++;
        if (tr !== t + 3) begin miscompares++; $display("FAIL read_latency: rvalid at T+%0d, required T+3", tr - t); end
        vectors++;
        if (d !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_data: got %h, required deadbeef", d); end
        vectors++;
        if (r !== RESP_OKAY) begin miscompares++; $display("FAIL read_rresp: got %b, required 00", r); end
    endtask

    task automatic test_strobe;
        logic [31:0] d;
        logic [1:0]  r, r2;
        wr(32'h8000_0020, 32'hAAAA_AAAA, 8'hFF, r);
        wr(32'h8000_0020, 32'h1122_3344, 8'h05, r2);
        vectors++;
        if ({r, r2} !== 4'b0000) begin miscompares++; $display("FAIL strobe_bresp: got %b/%b, required 00/00", r, r2); end
        rd(32'h8000_0020, d, r);
        vectors++;
        if (d !== 32'hAA22_AA44) begin miscompares++; $display("FAIL strobe_merge: got %h, required aa22aa44", d); end
    endtask

    task automatic test_aw_w_order;
        logic [31:0] addrs [2];
        logic [31:0] vals [2];
        int leads [2];
        logic [31:0] d;
        logic [1:0]  r;
        int tl, tb, extra;
        addrs[0] = 32'h8000_0040; vals[0] = 32'h0BAD_F00D; leads[0] = 3;
        addrs[1] = 32'h8000_0044; vals[1] = 32'h1234_5678; leads[1] = 0;
        for (int i = 0; i < 2; i++) begin
            wr_send(addrs[i], vals[i], 8'hFF, leads[i], tl);
            b_get(r, tb);
            vectors++;
            if (tb < tl + LAT + 1 || tb > tl + LAT + 2) begin
                miscompares++;
                $display("FAIL order_b_timing lead=%0d: bvalid at handshake+%0d, required +%0d..+%0d", leads[i], tb - tl, LAT + 1, LAT + 2);
            end
            vectors++;
            if (r !== RESP_OKAY) begin miscompares++; $display("FAIL order_bresp lead=%0d: got %b, required 00", leads[i], r); end
            extra = 0;
            for (int j = 0; j < 4; j++) begin
                if (bvalid) extra++;
                @(negedge clk);
            end
            vectors++;
            if (extra != 0) begin miscompares++; $display("FAIL order_single_b lead=%0d: %0d extra bvalid cycles, required 0", leads[i], extra); end
        end
        for (int i = 0; i < 2; i++) begin
            rd(addrs[i], d, r);
            vectors++;
            if (d !== vals[i]) begin miscompares++; $display("FAIL order_readback %h: got %h, required %h", addrs[i], d, vals[i]); end
        end
    endtask

    task automatic test_decerr;
        logic [31:0] d;
        logic [1:0]  r;
        wr(32'h8000_0000, 32'hC0FF_EE00, 8'h0F, r);
        rd(32'h7FFF_FFFC, d, r);
        vectors++;
        if (r !== RESP_DECERR) begin miscompares++; $display("FAIL decerr_rresp: got %b, required 11", r); end
        vectors++;
        if (d !== 32'h0) begin miscompares++; $display("FAIL decerr_rdata: got %h, required 0", d); end
        wr(32'h8004_0000, 32'hFFFF_FFFF, 8'h0F, r);
        vectors++;
        if (r !== RESP_DECERR) begin miscompares++; $display("FAIL decerr_bresp: got %b, required 11", r); end
        rd(32'h8000_0000, d, r);
        vectors++;
        if (d !== 32'hC0FF_EE00) begin miscompares++; $display("FAIL decerr_no_commit: word0 got %h, required c0ffee00", d); end
        wr(32'h8003_FFFC, 32'h600D_CAFE, 8'hFF, r);
        vectors++;
        if (r !== RESP_OKAY) begin miscompares++; $display("FAIL top_word_bresp: got %b, required 00", r); end
        rd(32'h8003_FFFC, d, r);
        vectors++;
        if ({d, r} !== {32'h600D_CAFE, RESP_OKAY}) begin miscompares++; $display("FAIL top_word_read: got %h/%b, required 600dcafe/00", d, r); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d;
        logic [1:0]  r;
        int t, tr, n;
        logic stable, early;
        ar_send(32'h8000_0010, t);
        n = 0;
        while (rvalid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n == 40) begin vectors++; miscompares++; $display("FAIL bp_timeout: rvalid low for %0d cycles, required within 40", n); end
        arvalid = 1'b1;
        araddr  = 32'h8000_0020;
        stable = 1'b1; early = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) stable = 1'b0;
            if (arready !== 1'b0) early = 1'b1;
        end
        vectors++;
        if (!stable) begin miscompares++; $display("FAIL bp_stable: rvalid=%b rdata=%h, required 1/deadbeef held", rvalid, rdata); end
        vectors++;
        if (early) begin miscompares++; $display("FAIL bp_arready: arready seen 1 during R stall, required 0"); end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        vectors++;
        if ({rvalid, arready} !== 2'b00) begin
            miscompares++;
            $display("FAIL bp_handshake_cycle: rvalid/arready got %b, required 00", {rvalid, arready});
        end
        ar_send(32'h8000_0020, t);
        r_get(d, r, tr);
        vectors++;
        if (d !== 32'hAA22_AA44) begin miscompares++; $display("FAIL bp_next_read: got %h, required aa22aa44", d); end
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] d;
        logic [1:0]  r;
        int tl;
        logic saw_b;
        wr(32'h8000_0030, 32'h5555_5555, 8'hFF, r);
        wr_send(32'h8000_0030, 32'h9999_9999, 8'h0F, 0, tl);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        saw_b = 1'b0;
        @(negedge clk);
        if (bvalid) saw_b = 1'b1;
        @(negedge clk);
        vectors++;
        if ({arready, awready, wready} !== 3'b111) begin
            miscompares++;
            $display("FAIL rst_ready: ar/aw/w ready got %b two cycles after reset, required 111", {arready, awready, wready});
        end
        repeat (6) begin
            if (bvalid) saw_b = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (saw_b) begin miscompares++; $display("FAIL rst_no_b: bvalid seen 1 after abandoned write, required 0"); end
        rd(32'h8000_0030, d, r);
        vectors++;
        if (d !== 32'h5555_5555) begin miscompares++; $display("FAIL rst_no_commit: got %h, required 55555555", d); end
    endtask

    initial begin
        test_reset;
        test_read_latency;
        test_strobe;
        test_aw_w_order;
        test_decerr;
        test_backpressure;
        test_reset_mid_write;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
